// File: rtl/rwc_chal_seq_pkg.sv
// Shared definitions for the challenge sequencer and the read-write-collision controller:
// FSM encoding, default bus widths and the response parity fold.
package rwc_chal_seq_pkg;

  localparam int unsigned RWC_ADDR_W = 10;
  localparam int unsigned RWC_DATA_W = 32;
  // Widest data bus the parity fold accepts; narrower buses are zero-extended.
  localparam int unsigned RWC_FOLD_W = 256;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_ACCUM     = 3'd4,
    ST_OUTPUT    = 3'd5
  } state_t;

  function automatic logic xor_fold(input logic [RWC_FOLD_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/rwc_wait_timer.sv
// Wait-phase watchdog: counts cycles since the last clear and flags the
// TIMEOUT-th cycle so the caller can abort on that same edge.
module rwc_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next count: clear, advance, or saturate at the expiry value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (!expired_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rwc_chal_seq.sv
// Challenge sequencer / response collector: issues RSP_BITS challenges to the
// collision controller, folds each response pair to one bit and hands out the packed word.
module rwc_chal_seq
  import rwc_chal_seq_pkg::*;
#(
  parameter int unsigned ADDR_W   = RWC_ADDR_W,
  parameter int unsigned DATA_W   = RWC_DATA_W,
  parameter int unsigned RSP_BITS = 32,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   seed_addr_i,
  input  logic [DATA_W-1:0]   pattern_i,
  output logic                busy_o,
  output logic                err_timeout_o,
  output logic                gen_enable_o,
  output logic [ADDR_W-1:0]   cha_addr_o,
  output logic [DATA_W-1:0]   cha_data_o,
  input  logic                rwc_available_i,
  input  logic [DATA_W-1:0]   rwc_rsp_write_i,
  input  logic [DATA_W-1:0]   rwc_rsp_clean_i,
  output logic [RSP_BITS-1:0] rsp_word_o,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i
);

  localparam int unsigned IDX_W = $clog2(RSP_BITS + 1);

  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic                bit_q;
  logic                avail_q;
  logic                busy_q;
  logic                err_q;
  logic                gen_en_q;
  logic [ADDR_W-1:0]   cha_addr_q;
  logic [DATA_W-1:0]   cha_data_q;
  logic [RSP_BITS-1:0] rsp_word_q;
  logic                rsp_valid_q;

  logic wait_state_s;
  logic progress_s;
  logic tmr_clr_s;
  logic expired_s;
  logic rsp_bit_s;

  assign rsp_bit_s = xor_fold(RWC_FOLD_W'(rwc_rsp_write_i ^ rwc_rsp_clean_i));

  // Wait-phase progress; the timer restarts whenever the FSM leaves a wait state.
  always_comb begin
    wait_state_s = 1'b0;
    progress_s   = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        wait_state_s = 1'b1;
        progress_s   = rwc_available_i;
      end
      ST_WAIT_BUSY: begin
        wait_state_s = 1'b1;
        progress_s   = ~rwc_available_i;
      end
      ST_WAIT_DONE: begin
        wait_state_s = 1'b1;
        progress_s   = rwc_available_i & ~avail_q;
      end
      default: begin
        wait_state_s = 1'b0;
        progress_s   = 1'b0;
      end
    endcase
    tmr_clr_s = ~wait_state_s | progress_s;
  end

  rwc_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .clr_i     (tmr_clr_s),
    .expired_o (expired_s)
  );

  // Sequencer FSM with all registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      bit_q       <= 1'b0;
      avail_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      gen_en_q    <= 1'b0;
      cha_addr_q  <= '0;
      cha_data_q  <= '0;
      rsp_word_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      avail_q  <= rwc_available_i;
      gen_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            cha_addr_q <= seed_addr_i;
            cha_data_q <= pattern_i;
            idx_q      <= '0;
            rsp_word_q <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (progress_s) begin
            gen_en_q <= 1'b1;
            state_q  <= ST_WAIT_BUSY;
          end else if (expired_s) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT_BUSY: begin
          if (progress_s) begin
            state_q <= ST_WAIT_DONE;
          end else if (expired_s) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT_DONE: begin
          // Responses are already registered by the controller when available rises.
          if (progress_s) begin
            bit_q   <= rsp_bit_s;
            state_q <= ST_ACCUM;
          end else if (expired_s) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_ACCUM: begin
          for (int i = 0; i < int'(RSP_BITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
              rsp_word_q[i] <= bit_q;
            end
          end
          if (idx_q == IDX_W'(RSP_BITS - 1)) begin
            rsp_valid_q <= 1'b1;
            state_q     <= ST_OUTPUT;
          end else begin
            idx_q      <= idx_q + IDX_W'(1);
            cha_addr_q <= cha_addr_q + ADDR_W'(1);
            state_q    <= ST_ISSUE;
          end
        end
        ST_OUTPUT: begin
          if (rsp_valid_q && rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          busy_q      <= 1'b0;
          rsp_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign err_timeout_o = err_q;
  assign gen_enable_o  = gen_en_q;
  assign cha_addr_o    = cha_addr_q;
  assign cha_data_o    = cha_data_q;
  assign rsp_word_o    = rsp_word_q;
  assign rsp_valid_o   = rsp_valid_q;

endmodule

// File: tb/tb_rwc_chal_seq.sv
// Directed bench for rwc_chal_seq with a behavioural collision-controller model
// (available drops 2 cycles after gen_enable, rises 4 cycles later).
module tb_rwc_chal_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [9:0]  seed_addr;
  logic [31:0] pattern;
  logic        busy, err_timeout, gen_enable;
  logic [9:0]  cha_addr;
  logic [31:0] cha_data;
  logic        avail;
  logic [31:0] rsp_write, rsp_clean;
  logic [3:0]  rsp_word;
  logic        rsp_valid;
  logic        rsp_ready;

  logic        stuck, equal_mode;
  logic [2:0]  tick;
  logic [9:0]  addr_log[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  rwc_chal_seq #(
    .ADDR_W(10), .DATA_W(32), .RSP_BITS(4), .TIMEOUT(15)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .seed_addr_i(seed_addr),
    .pattern_i(pattern), .busy_o(busy), .err_timeout_o(err_timeout),
    .gen_enable_o(gen_enable), .cha_addr_o(cha_addr), .cha_data_o(cha_data),
    .rwc_available_i(avail), .rwc_rsp_write_i(rsp_write), .rwc_rsp_clean_i(rsp_clean),
    .rsp_word_o(rsp_word), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready)
  );

  // Write-readback table; with clean=0 the per-address parity is {1,0,1,1}.
  function automatic logic [31:0] wtab(input logic [9:0] a);
    case (a[1:0])
      2'd0:    return 32'h0000_0001;
      2'd1:    return 32'hA5A5_A5A5;
      2'd2:    return 32'h0000_0007;
      default: return 32'hFFFF_FFFE;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      avail <= 1'b1; tick <= 3'd0; rsp_write <= 32'h0; rsp_clean <= 32'h0;
    end else if (stuck) begin
      avail <= 1'b0; tick <= 3'd0;
    end else if (gen_enable) begin
      tick <= 3'd1;
    end else if (tick == 3'd6) begin
      avail <= 1'b1; tick <= 3'd0;
    end else if (tick != 3'd0) begin
      if (tick == 3'd2) begin
        avail     <= 1'b0;
        rsp_write <= wtab(cha_addr);
        rsp_clean <= equal_mode ? wtab(cha_addr) : 32'h0;
      end
      tick <= tick + 3'd1;
    end else begin
      avail <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rstn && gen_enable) addr_log.push_back(cha_addr);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [9:0] s, input logic [31:0] p);
    seed_addr = s; pattern = p; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid_in_budget"}, rsp_valid, 1'b1);
  endtask

  task automatic check_addrs(input string tag, input logic [9:0] a0, input logic [9:0] a1,
                             input logic [9:0] a2, input logic [9:0] a3);
    logic [9:0] exp [4];
    exp = '{a0, a1, a2, a3};
    check_eq({tag, "_gen_count"}, addr_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check_eq({tag, "_addr"}, (i < addr_log.size()) ? 64'(addr_log[i]) : 64'hDEAD, 64'(exp[i]));
  endtask

  task automatic accept(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "_hs_valid"}, rsp_valid, 1'b0);
    check_eq({tag, "_hs_busy"}, busy, 1'b0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stable;
    int   n;
    rstn = 1'b0; start = 1'b0; seed_addr = 10'h0; pattern = 32'h0;
    rsp_ready = 1'b0; stuck = 1'b0; equal_mode = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_outputs", {busy, err_timeout, gen_enable, rsp_valid}, 4'b0000);
    check_eq("rst_cha_addr", cha_addr, 10'h0);
    check_eq("rst_cha_data", cha_data, 32'h0);
    check_eq("rst_rsp_word", rsp_word, 4'h0);
    rstn = 1'b1;
    @(negedge clk);

    // Test 1: seed 0, word 4'b1101, valid held; start during handshake ignored
    addr_log.delete();
    do_start(10'h000, 32'hDEAD_BEEF);
    check_eq("t1_busy", busy, 1'b1);
    check_eq("t1_cha_data", cha_data, 32'hDEAD_BEEF);
    wait_valid("t1", 200);
    check_eq("t1_word", rsp_word, 4'b1101);
    check_addrs("t1", 10'h000, 10'h001, 10'h002, 10'h003);
    repeat (3) @(negedge clk);
    check_eq("t1_valid_held", rsp_valid, 1'b1);
    start = 1'b1;
    accept("t1");
    start = 1'b0;
    @(negedge clk);
    check_eq("t1_start_on_hs_ignored", busy, 1'b0);
    check_eq("t1_word_kept", rsp_word, 4'b1101);

    // Test 2 + 4: address wrap, then 50-cycle consumer stall with start pulses
    addr_log.delete();
    do_start(10'h3FE, 32'h1234_5678);
    wait_valid("t2", 200);
    check_eq("t2_word", rsp_word, 4'b0111);
    check_addrs("t2", 10'h3FE, 10'h3FF, 10'h000, 10'h001);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      start = (i % 10 == 0);
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_word !== 4'b0111 || busy !== 1'b1) stable = 1'b0;
    end
    start = 1'b0;
    check_eq("t4_stall_stable", stable, 1'b1);
    check_eq("t4_no_new_gen", addr_log.size(), 4);
    accept("t4");
    @(negedge clk);
    check_eq("t4_idle_after_hs", busy, 1'b0);
    check_eq("t4_word_kept", rsp_word, 4'b0111);

    // Test 3: controller never available -> timeout after 15 cycles in ISSUE
    stuck = 1'b1;
    repeat (3) @(negedge clk);
    addr_log.delete();
    do_start(10'h000, 32'hCAFE_F00D);
    repeat (14) @(negedge clk);
    check_eq("t3_err_before", err_timeout, 1'b0);
    check_eq("t3_busy_before", busy, 1'b1);
    @(negedge clk);
    check_eq("t3_err_set", err_timeout, 1'b1);
    check_eq("t3_busy_clr", busy, 1'b0);
    check_eq("t3_no_valid", rsp_valid, 1'b0);
    check_eq("t3_no_gen", addr_log.size(), 0);
    stuck = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t3_err_sticky", err_timeout, 1'b1);
    do_start(10'h004, 32'h0F0F_0F0F);
    check_eq("t3_err_cleared", err_timeout, 1'b0);
    wait_valid("t3", 200);
    check_eq("t3_word", rsp_word, 4'b1101);
    accept("t3");

    // Test 5: reset in WAIT_DONE of challenge 2, then a clean rerun
    addr_log.delete();
    do_start(10'h000, 32'h5555_AAAA);
    n = 0;
    while (addr_log.size() < 2 && n < 100) begin @(negedge clk); n++; end
    check_eq("t5_reach_ch2", addr_log.size(), 2);
    n = 0;
    while (avail !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    check_eq("t5_ctrl_busy", avail, 1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check_eq("t5_rst_outputs", {busy, err_timeout, gen_enable, rsp_valid}, 4'b0000);
    check_eq("t5_rst_cha_addr", cha_addr, 10'h0);
    check_eq("t5_rst_cha_data", cha_data, 32'h0);
    check_eq("t5_rst_word", rsp_word, 4'h0);
    rstn = 1'b1;
    @(negedge clk);
    addr_log.delete();
    do_start(10'h000, 32'h5555_AAAA);
    wait_valid("t5", 200);
    check_eq("t5_word", rsp_word, 4'b1101);
    check_addrs("t5", 10'h000, 10'h001, 10'h002, 10'h003);
    accept("t5");

    // Test 6: identical readbacks -> all-zero word
    equal_mode = 1'b1;
    addr_log.delete();
    do_start(10'h008, 32'hFFFF_0000);
    wait_valid("t6", 200);
    check_eq("t6_word", rsp_word, 4'b0000);
    accept("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
